// File: rtl/fetch_icache_sa_pkg.sv
// Shared definitions for the set-associative fetch cache.
// Holds the FSM encodings and the address-split width helpers.
package fetch_icache_sa_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/fetch_icache_sa_if.sv
// Fetch-stage bus bundle: pc_reg request, if_id result and memctrl word handshake.
interface fetch_icache_sa_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rdy_in;
  logic [ADDR_W-1:0] pc_in;
  logic              branch_taken_in;
  logic              flush_in;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_done_in;
  logic [INST_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              branch_taken_out;
  logic              valid_out;
  logic              stall_out;

  modport slave (
    input  rdy_in, pc_in, branch_taken_in, flush_in, mem_done_in, mem_data_in,
    output mem_req_out, mem_addr_out, pc_out, inst_out, branch_taken_out, valid_out, stall_out
  );

  modport master (
    output rdy_in, pc_in, branch_taken_in, flush_in, mem_done_in, mem_data_in,
    input  mem_req_out, mem_addr_out, pc_out, inst_out, branch_taken_out, valid_out, stall_out
  );
endinterface

// File: rtl/fetch_icache_sa_tag_array.sv
// Per-way valid/tag storage with one LRU bit per set (two-way only).
// Lookup is combinational; write, touch and flush act on the clock edge.
module icache_tag_array #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int IB   = 6,
  parameter int TB   = 24
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [IB-1:0] i_index,
  input  logic [TB-1:0] i_tag,
  output logic          o_hit,
  output logic          o_hit_way,
  output logic          o_victim,
  input  logic          i_touch,
  input  logic          i_wr_en,
  input  logic          i_wr_way,
  input  logic [IB-1:0] i_wr_index,
  input  logic [TB-1:0] i_wr_tag,
  input  logic          i_flush
);

  logic [SETS-1:0] r_valid [WAYS];
  logic [TB-1:0]   r_tag   [WAYS][SETS];
  logic [WAYS-1:0] w_hit_vec;

  always_comb begin
    w_hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w][i_index] && (r_tag[w][i_index] == i_tag);
    end
  end

  assign o_hit = |w_hit_vec;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else if (i_flush) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_way][i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_wr_en) r_tag[i_wr_way][i_wr_index] <= i_wr_tag;
  end

  generate
    if (WAYS == 2) begin : g_lru
      // r_lru names the way to evict next.
      logic [SETS-1:0] r_lru;

      assign o_hit_way = w_hit_vec[1];
      assign o_victim  = !r_valid[0][i_index] ? 1'b0 :
                         (!r_valid[1][i_index] ? 1'b1 : r_lru[i_index]);

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_lru <= '0;
        end else if (i_flush) begin
          r_lru <= '0;
        end else if (i_wr_en) begin
          r_lru[i_wr_index] <= ~i_wr_way;
        end else if (i_touch) begin
          r_lru[i_index] <= ~w_hit_vec[1];
        end
      end
    end else begin : g_direct
      assign o_hit_way = 1'b0;
      assign o_victim  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fetch_icache_sa.sv
// Instruction-fetch stage with a set-associative cache and a sequential
// multi-word refill FSM over the memctrl word handshake.
module fetch_icache_sa
  import fetch_icache_sa_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  fetch_icache_sa_if.slave  bus
);

  localparam int OB = off_bits(LINE_WORDS);
  localparam int IB = idx_bits(SETS);
  localparam int TB = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int LB = ADDR_W - OB - 2;

  logic [0:0]        r_state;
  logic [OB-1:0]     r_cnt;
  logic [LB-1:0]     r_line;
  logic              r_victim;
  logic [INST_W-1:0] r_buf  [LINE_WORDS];
  logic [INST_W-1:0] r_data [WAYS][SETS][LINE_WORDS];

  logic [OB-1:0] w_off;
  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag;
  logic          w_hit, w_hit_way, w_victim;
  logic          w_run, w_fill, w_touch, w_take;
  logic          w_unused;

  assign w_off    = bus.pc_in[OB+1:2];
  assign w_idx    = bus.pc_in[OB+IB+1:OB+2];
  assign w_tag    = bus.pc_in[ADDR_W-1:OB+IB+2];
  assign w_unused = &{1'b0, bus.pc_in[1:0]};

  // A flush cycle does no normal work, and nothing moves while rdy_in is low.
  assign w_run   = bus.rdy_in & ~bus.flush_in;
  assign w_take  = w_run & (r_state == ST_REFILL) & bus.mem_done_in;
  assign w_fill  = w_take & (&r_cnt);
  assign w_touch = w_run & (r_state == ST_IDLE) & w_hit;

  icache_tag_array #(.SETS(SETS), .WAYS(WAYS), .IB(IB), .TB(TB)) u_tags (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_index    (w_idx),
    .i_tag      (w_tag),
    .o_hit      (w_hit),
    .o_hit_way  (w_hit_way),
    .o_victim   (w_victim),
    .i_touch    (w_touch),
    .i_wr_en    (w_fill),
    .i_wr_way   (r_victim),
    .i_wr_index (r_line[IB-1:0]),
    .i_wr_tag   (r_line[LB-1:IB]),
    .i_flush    (bus.rdy_in & bus.flush_in)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_line   <= '0;
      r_victim <= 1'b0;
    end else if (w_run) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_hit) begin
            r_line   <= bus.pc_in[ADDR_W-1:OB+2];
            r_victim <= w_victim;
            r_cnt    <= '0;
            r_state  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (bus.mem_done_in) begin
            r_cnt <= r_cnt + OB'(1);
            if (&r_cnt) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else if (bus.rdy_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end
  end

  // The last word bypasses the buffer straight into the victim line.
  always_ff @(posedge clk_in) begin
    if (w_take) r_buf[r_cnt] <= bus.mem_data_in;
    if (w_fill) begin
      for (int k = 0; k < LINE_WORDS - 1; k++) begin
        r_data[r_victim][r_line[IB-1:0]][k[OB-1:0]] <= r_buf[k[OB-1:0]];
      end
      r_data[r_victim][r_line[IB-1:0]][LINE_WORDS-1] <= bus.mem_data_in;
    end
  end

  always_comb begin
    bus.mem_req_out      = 1'b0;
    bus.mem_addr_out     = '0;
    bus.valid_out        = 1'b0;
    bus.stall_out        = 1'b0;
    bus.pc_out           = '0;
    bus.inst_out         = '0;
    bus.branch_taken_out = 1'b0;
    if (rst_in && bus.rdy_in) begin
      if (bus.flush_in) begin
        bus.stall_out = 1'b1;
      end else if (r_state == ST_REFILL) begin
        bus.mem_req_out  = 1'b1;
        bus.mem_addr_out = {r_line, r_cnt, 2'b00};
        bus.stall_out    = 1'b1;
      end else if (w_hit) begin
        bus.valid_out        = 1'b1;
        bus.pc_out           = bus.pc_in;
        bus.inst_out         = r_data[w_hit_way][w_idx][w_off];
        bus.branch_taken_out = bus.branch_taken_in;
      end else begin
        bus.stall_out = 1'b1;
      end
    end else begin
      bus.stall_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_icache_sa.sv
// Directed bench for fetch_icache_sa with default parameters (64 sets, 2 ways, 4-word lines).
module tb_fetch_icache_sa;

  logic clk_in;
  logic rst_in;
  int   n_tests;
  int   n_fail;

  fetch_icache_sa_if bus ();

  fetch_icache_sa dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req"},   32'(bus.mem_req_out), 32'd0);
    chk({tag, "_addr"},  bus.mem_addr_out,     32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_out),   32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_out),   32'd0);
    chk({tag, "_pc"},    bus.pc_out,           32'd0);
    chk({tag, "_inst"},  bus.inst_out,         32'd0);
    chk({tag, "_bt"},    32'(bus.branch_taken_out), 32'd0);
  endtask

  task automatic chk_miss(input string tag, input logic [31:0] pc);
    bus.pc_in = pc;
    #1;
    chk({tag, "_valid"}, 32'(bus.valid_out),   32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_out),   32'd1);
    chk({tag, "_req"},   32'(bus.mem_req_out), 32'd0);
  endtask

  task automatic refill_word(input string tag, input logic [31:0] addr);
    bus.mem_done_in = 1'b1;
    bus.mem_data_in = mdat(addr);
    #1;
    chk({tag, "_req"},   32'(bus.mem_req_out), 32'd1);
    chk({tag, "_addr"},  bus.mem_addr_out,     addr);
    chk({tag, "_stall"}, 32'(bus.stall_out),   32'd1);
    chk({tag, "_valid"}, 32'(bus.valid_out),   32'd0);
    tick();
    bus.mem_done_in = 1'b0;
    bus.mem_data_in = 32'd0;
  endtask

  task automatic do_refill(input string tag, input logic [31:0] pc);
    chk_miss({tag, "_miss"}, pc);
    tick();
    for (int i = 0; i < 4; i++) begin
      refill_word({tag, "_w"}, {pc[31:4], 4'h0} + 32'(i * 4));
    end
  endtask

  task automatic chk_hit(input string tag, input logic [31:0] pc, input logic bt);
    bus.pc_in           = pc;
    bus.branch_taken_in = bt;
    #1;
    chk({tag, "_valid"}, 32'(bus.valid_out),   32'd1);
    chk({tag, "_stall"}, 32'(bus.stall_out),   32'd0);
    chk({tag, "_req"},   32'(bus.mem_req_out), 32'd0);
    chk({tag, "_pc"},    bus.pc_out,           pc);
    chk({tag, "_inst"},  bus.inst_out,         mdat(pc));
    chk({tag, "_bt"},    32'(bus.branch_taken_out), 32'(bt));
    tick();
    bus.branch_taken_in = 1'b0;
  endtask

  initial begin
    n_tests             = 0;
    n_fail              = 0;
    rst_in              = 1'b0;
    bus.rdy_in          = 1'b1;
    bus.pc_in           = 32'd0;
    bus.branch_taken_in = 1'b0;
    bus.flush_in        = 1'b0;
    bus.mem_done_in     = 1'b0;
    bus.mem_data_in     = 32'd0;

    repeat (2) @(posedge clk_in);
    #1;
    chk_idle_zero("reset");
    rst_in = 1'b1;

    // Cold miss then line hits.
    do_refill("cold", 32'h0000_1000);
    chk_hit("hit1000", 32'h0000_1000, 1'b0);
    chk_hit("hit1004", 32'h0000_1004, 1'b1);
    chk_hit("hit1008", 32'h0000_1008, 1'b0);
    chk_hit("hit100c", 32'h0000_100C, 1'b0);

    // Same-index conflict: 0x1000 way0, 0x2000 way1, touch 0x1000, 0x3000 evicts 0x2000.
    do_refill("fill2000", 32'h0000_2000);
    chk_hit("hit2000", 32'h0000_2000, 1'b0);
    chk_hit("touch1000", 32'h0000_1000, 1'b0);
    do_refill("fill3000", 32'h0000_3000);
    chk_hit("hit3000", 32'h0000_3000, 1'b0);
    chk_hit("keep1000", 32'h0000_1000, 1'b0);
    chk_miss("evict2000", 32'h0000_2000);

    // Flush after two words of the 0x2000 refill, with a done pulse in the flush cycle.
    tick();
    refill_word("fl_w0", 32'h0000_2000);
    refill_word("fl_w1", 32'h0000_2004);
    bus.flush_in    = 1'b1;
    bus.mem_done_in = 1'b1;
    bus.mem_data_in = 32'hDEAD_BEEF;
    #1;
    chk("flush_req",   32'(bus.mem_req_out), 32'd0);
    chk("flush_stall", 32'(bus.stall_out),   32'd1);
    chk("flush_valid", 32'(bus.valid_out),   32'd0);
    tick();
    bus.flush_in    = 1'b0;
    bus.mem_done_in = 1'b0;
    bus.mem_data_in = 32'd0;
    chk_miss("post_flush2000", 32'h0000_2000);
    do_refill("refetch1000", 32'h0000_1000);
    chk_hit("rehit1000", 32'h0000_1000, 1'b1);

    // rdy_in low for five cycles in the middle of a refill.
    chk_miss("miss4040", 32'h0000_4040);
    tick();
    refill_word("rdy_w0", 32'h0000_4040);
    bus.rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_done_in = (i == 1);
      bus.mem_data_in = 32'hBAD0_0000;
      #1;
      chk("frz_req",   32'(bus.mem_req_out), 32'd0);
      chk("frz_stall", 32'(bus.stall_out),   32'd0);
      chk("frz_valid", 32'(bus.valid_out),   32'd0);
      tick();
    end
    bus.mem_done_in = 1'b0;
    bus.mem_data_in = 32'd0;
    bus.rdy_in      = 1'b1;
    refill_word("rdy_w1", 32'h0000_4044);
    refill_word("rdy_w2", 32'h0000_4048);
    refill_word("rdy_w3", 32'h0000_404C);
    chk_hit("hit4040", 32'h0000_4040, 1'b0);
    chk_hit("hit4044", 32'h0000_4044, 1'b0);

    // Asynchronous reset between edges in the middle of a refill.
    chk_miss("miss5000", 32'h0000_5000);
    tick();
    refill_word("rst_w0", 32'h0000_5000);
    #3;
    rst_in = 1'b0;
    #1;
    chk_idle_zero("async_rst");
    tick();
    tick();
    #2;
    rst_in = 1'b1;
    chk_miss("postrst1000", 32'h0000_1000);
    chk_miss("postrst4040", 32'h0000_4040);
    chk_miss("postrst5000", 32'h0000_5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_icache_sa.md
Name: fetch_icache_sa

Overview:
- Next-generation instruction-fetch stage with a parametrised set-associative instruction cache.
- Multi-word lines are refilled by a sequential refill FSM over the memory-controller word handshake.
- Supports a full-cache flush for fence.i and a stall freeze on rdy_in.
- Sits between pc_reg, memctrl and if_id; replaces the single-word direct-mapped fetch stage.

Parameters:
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction word width.
- SETS, 64, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; legal values 1 or 2.
- LINE_WORDS, 4, instruction words per line; power of 2, at least 2.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes the block.
- pc_in  in  ADDR_W  fetch PC from pc_reg; bits [1:0] are zero.
- branch_taken_in  in  1  prediction bit from pc_reg.
- flush_in  in  1  invalidate the whole cache (fence.i).
- mem_req_out  out  1  word-read request to memctrl.
- mem_addr_out  out  ADDR_W  word address of the request.
- mem_done_in  in  1  one-cycle pulse: the requested word is on mem_data_in.
- mem_data_in  in  INST_W  returned word.
- pc_out  out  ADDR_W  PC to if_id.
- inst_out  out  INST_W  instruction to if_id.
- branch_taken_out  out  1  passthrough of branch_taken_in, qualified by valid_out.
- valid_out  out  1  pc_out, inst_out and branch_taken_out are valid this cycle.
- stall_out  out  1  fetch stall request to pc_reg.

Behaviour:
- Address split:
  - offset = pc[2+OB-1:2], with OB = log2(LINE_WORDS);
  - index = next log2(SETS) bits;
  - tag = remaining upper bits.
- Storage per set and way: valid bit, tag, and LINE_WORDS words. One LRU bit per set is present only when WAYS=2.
- Reset (rst_in low, asynchronous):
  - all valid bits 0, LRU bits 0, FSM goes to IDLE, word counter 0;
  - mem_req_out=0, mem_addr_out=0, valid_out=0, stall_out=0, pc_out=0, inst_out=0, branch_taken_out=0.
  - Reset during REFILL abandons the refill; no line is installed.
- rdy_in low: all state holds. Outputs valid_out=0, stall_out=0, mem_req_out=0.
- FSM states: IDLE, REFILL.
- IDLE:
  - Lookup is combinational. Hit = a way whose valid bit is set and whose tag matches.
  - On hit, in the same cycle: valid_out=1, pc_out=pc_in, inst_out=selected word, branch_taken_out=branch_taken_in, stall_out=0.
  - On a hit clock edge, that set's LRU points to the other way.
  - On miss: valid_out=0, stall_out=1.
  - On the miss clock edge:
    - latch the line base address (offset bits cleared);
    - choose the victim: way 0 if it is invalid, otherwise way 1 if it is invalid, otherwise the LRU way;
    - clear the counter and go to REFILL.
- REFILL:
  - mem_req_out=1; mem_addr_out = base + 4*cnt; stall_out=1; valid_out=0.
  - On mem_done_in: the word is written to the line buffer and cnt increments.
  - On the done edge for word LINE_WORDS-1:
    - write the line, tag and valid=1 into the victim;
    - set LRU to the other way;
    - go to IDLE.
  - No bypass: the refilled PC hits on the next cycle.
  - Miss penalty = LINE_WORDS memory transactions + 1 cycle.
- pc_in changes during REFILL (redirect): the refill completes for the latched line, then the new PC is looked up. A stale line is harmless.
- flush_in:
  - Clears all valid and LRU bits on the edge and forces IDLE.
  - While flush_in=1: valid_out=0, stall_out=1, mem_req_out=0.
  - If flush_in arrives during REFILL, the refill is aborted and a mem_done_in in that same cycle is ignored.
  - memctrl treats a dropped mem_req_out as a cancel.
- WAYS=1: the victim is always way 0 and no LRU storage exists.
- mem_done_in while in IDLE: ignored.

Decomposition:
- Shared package (defines.v additions):
  - FSM state encodings (IDLE, REFILL);
  - derived widths OB, IB, TB;
  - macros for the offset, index and tag slices.
- One sub-module, icache_tag_array:
  - per-way valid and tag storage plus LRU;
  - ports: index, compare tag, hit vector, and a write port (way, tag, set valid), plus flush.
- Data arrays and the refill FSM stay in the top module.

Test Plan:
- Cold miss, default parameters: pc_in=0x0000_1000.
  - Expect mem_addr_out 0x1000, 0x1004, 0x1008, 0x100C with a done pulse for each; stall_out=1 throughout.
  - On the next cycle: valid_out=1, inst_out = the first returned word.
- Line hits: pc_in=0x1004, then 0x1008, then 0x100C, after the refill above.
  - Expect valid_out=1 each cycle, mem_req_out=0, and the correct words.
- 2-way conflict:
  - Fill 0x1000 and 0x2000 (same index), touch 0x1000, then miss on 0x3000.
  - Expect 0x2000 evicted: a later 0x1000 hits; a later 0x2000 misses.
- flush_in pulse mid-REFILL, after 2 words, with mem_done_in=1 in the same cycle.
  - Expect mem_req_out=0 on the next cycle and the FSM in IDLE.
  - Expect 0x1000 to miss again with a refill restarting at word 0.
- rdy_in=0 for 5 cycles mid-REFILL.
  - Expect outputs 0, counter and addresses held, and the refill resuming at the same word.
- rst_in asserted asynchronously mid-REFILL, between clock edges.
  - Expect all outputs 0 immediately and every prior line to miss after release.
